// File: rtl/judge_pkg.sv
// Shared types for the rhythm-game judgement controller: grade encodings,
// per-track FSM states and the note-age counter width.
package judge_pkg;

  localparam logic [1:0] GR_NONE    = 2'b00;
  localparam logic [1:0] GR_MISS    = 2'b01;
  localparam logic [1:0] GR_GOOD    = 2'b10;
  localparam logic [1:0] GR_PERFECT = 2'b11;

  localparam int unsigned AGE_W = 8;

  typedef logic [1:0] grade_t;

  typedef enum logic {
    StIdle,
    StPending
  } trk_state_e;

  // Good and Perfect both have the upper bit set.
  function automatic logic is_hit(grade_t g);
    return g[1];
  endfunction

endpackage

// File: rtl/judge_track_fsm.sv
// One note track: button edge detect, note-age counter and a registered grade
// that is valid for exactly one cycle after the deciding press/tick/note edge.
module judge_track_fsm
  import judge_pkg::*;
#(
  parameter int unsigned PerfectMs = 30,
  parameter int unsigned GoodMs    = 80
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   tick_i,
  input  logic   btn_i,
  input  logic   note_ctr_i,
  output grade_t grade_o
);

  trk_state_e       state_q;
  logic [AGE_W-1:0] age_q;
  logic             prev_q;
  grade_t           grade_q;
  logic             press;

  assign press   = btn_i & ~prev_q;
  assign grade_o = grade_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      age_q   <= '0;
      prev_q  <= 1'b0;
      grade_q <= GR_NONE;
    end else begin
      prev_q  <= btn_i;
      grade_q <= GR_NONE;
      case (state_q)
        StIdle: begin
          if (note_ctr_i) begin
            state_q <= StPending;
            age_q   <= '0;
          end
        end
        StPending: begin
          // Press beats both a new note and a timeout in the same cycle.
          if (press) begin
            grade_q <= (age_q <= AGE_W'(PerfectMs)) ? GR_PERFECT : GR_GOOD;
            if (note_ctr_i) age_q   <= '0;
            else            state_q <= StIdle;
          end else if (note_ctr_i) begin
            grade_q <= GR_MISS;
            age_q   <= '0;
          end else if (tick_i) begin
            if (age_q == AGE_W'(GoodMs)) begin
              grade_q <= GR_MISS;
              state_q <= StIdle;
            end else if (age_q != '1) begin
              age_q <= age_q + AGE_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/judge_ctrl_multi.sv
// Multi-track judgement controller: per-track FSMs feed a lowest-index
// arbiter, combo counter, judgement hold timer and piezo sound timer.
module judge_ctrl_multi
  import judge_pkg::*;
#(
  parameter int unsigned N_TRACKS   = 4,
  parameter int unsigned PITCH_W    = 32,
  parameter int unsigned PERFECT_MS = 30,
  parameter int unsigned GOOD_MS    = 80,
  parameter int unsigned SOUND_MS   = 100,
  parameter int unsigned HOLD_MS    = 200,
  parameter int unsigned COMBO_W    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_tick,
  input  logic [N_TRACKS-1:0]           i_btn,
  input  logic [N_TRACKS-1:0]           i_note_ctr,
  input  logic [N_TRACKS*PITCH_W-1:0]   i_pitch,
  output logic [1:0]                    o_judge,
  output logic [2:0]                    o_judge_trk,
  output logic                          o_judge_vld,
  output logic                          o_play_en,
  output logic [PITCH_W-1:0]            o_cnt_limit,
  output logic [COMBO_W-1:0]            o_combo
);

  localparam int unsigned HoldW  = $clog2(HOLD_MS + 1);
  localparam int unsigned SoundW = $clog2(SOUND_MS + 1);
  localparam int unsigned SumW   = COMBO_W + 4;
  localparam logic [COMBO_W-1:0] ComboMax = '1;

  grade_t grades [N_TRACKS];

  for (genvar k = 0; k < N_TRACKS; k++) begin : g_trk
    judge_track_fsm #(
      .PerfectMs(PERFECT_MS),
      .GoodMs   (GOOD_MS)
    ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (i_tick),
      .btn_i     (i_btn[k]),
      .note_ctr_i(i_note_ctr[k]),
      .grade_o   (grades[k])
    );
  end

  logic               any_grade, any_hit, any_miss;
  logic [2:0]         disp_sel;
  grade_t             disp_grade;
  logic [PITCH_W-1:0] hit_pitch;
  logic [3:0]         pop;
  logic [SumW-1:0]    combo_sum;
  logic [COMBO_W-1:0] combo_next;
  logic [HoldW-1:0]   hold_q;
  logic [SoundW-1:0]  sound_q;

  // Scan high-to-low so the last assignment is the lowest-index track.
  always_comb begin
    any_grade  = 1'b0;
    any_hit    = 1'b0;
    any_miss   = 1'b0;
    disp_sel   = '0;
    disp_grade = GR_NONE;
    hit_pitch  = '0;
    pop        = '0;
    for (int k = N_TRACKS - 1; k >= 0; k--) begin
      if (grades[k] != GR_NONE) begin
        any_grade  = 1'b1;
        disp_sel   = 3'(k);
        disp_grade = grades[k];
      end
      if (is_hit(grades[k])) begin
        any_hit   = 1'b1;
        hit_pitch = i_pitch[k*PITCH_W +: PITCH_W];
        pop       = pop + 4'd1;
      end
      if (grades[k] == GR_MISS) any_miss = 1'b1;
    end
    combo_sum  = SumW'(o_combo) + SumW'(pop);
    combo_next = (combo_sum > SumW'(ComboMax)) ? ComboMax : combo_sum[COMBO_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_judge     <= GR_NONE;
      o_judge_trk <= '0;
      o_judge_vld <= 1'b0;
      o_play_en   <= 1'b0;
      o_cnt_limit <= '0;
      o_combo     <= '0;
      hold_q      <= '0;
      sound_q     <= '0;
    end else begin
      o_judge_vld <= 1'b0;
      if (any_grade) begin
        o_judge     <= disp_grade;
        o_judge_trk <= disp_sel;
        o_judge_vld <= 1'b1;
        hold_q      <= HoldW'(HOLD_MS);
      end else if (i_tick && hold_q != '0) begin
        hold_q <= hold_q - HoldW'(1);
        if (hold_q == HoldW'(1)) o_judge <= GR_NONE;
      end

      if (any_miss)     o_combo <= '0;
      else if (any_hit) o_combo <= combo_next;

      if (any_hit) begin
        o_play_en   <= 1'b1;
        o_cnt_limit <= hit_pitch;
        sound_q     <= SoundW'(SOUND_MS);
      end else if (i_tick) begin
        if (sound_q == '0) o_play_en <= 1'b0;
        else               sound_q   <= sound_q - SoundW'(1);
      end
    end
  end

endmodule

// File: tb/tb_judge_ctrl_multi.sv
// Scoreboard bench: stimulus pushes expected judgements, a monitor pops and
// compares on every o_judge_vld pulse; a COMBO_W=3 copy checks saturation.
module tb_judge_ctrl_multi;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_tick;
  logic [3:0]   i_btn;
  logic [3:0]   i_note_ctr;
  logic [127:0] i_pitch;
  logic [1:0]   o_judge;
  logic [2:0]   o_judge_trk;
  logic         o_judge_vld;
  logic         o_play_en;
  logic [31:0]  o_cnt_limit;
  logic [9:0]   o_combo;
  logic [1:0]   s_judge;
  logic [2:0]   s_judge_trk;
  logic         s_judge_vld;
  logic         s_play_en;
  logic [31:0]  s_cnt_limit;
  logic [2:0]   s_combo;

  always #5 clk = ~clk;

  assign i_pitch = {32'h0000_4444, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111};

  judge_ctrl_multi u_dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_btn(i_btn), .i_note_ctr(i_note_ctr),
    .i_pitch(i_pitch), .o_judge(o_judge), .o_judge_trk(o_judge_trk),
    .o_judge_vld(o_judge_vld), .o_play_en(o_play_en), .o_cnt_limit(o_cnt_limit),
    .o_combo(o_combo)
  );

  judge_ctrl_multi #(.COMBO_W(3)) u_sat (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_btn(i_btn), .i_note_ctr(i_note_ctr),
    .i_pitch(i_pitch), .o_judge(s_judge), .o_judge_trk(s_judge_trk),
    .o_judge_vld(s_judge_vld), .o_play_en(s_play_en), .o_cnt_limit(s_cnt_limit),
    .o_combo(s_combo)
  );

  typedef struct {
    logic [1:0]  judge;
    logic [2:0]  trk;
    logic [9:0]  combo;
    bit          snd;
    logic [31:0] limit;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [31:0] pitch_of(int k);
    return 32'h1111 * (k + 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(logic [1:0] j, int trk, int combo, bit snd, logic [31:0] limit);
    exp_t e;
    e.judge = j;
    e.trk   = 3'(trk);
    e.combo = 10'(combo);
    e.snd   = snd;
    e.limit = limit;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_judge_vld) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_vld: got judge=%0h trk=%0d, expected no judgement",
                   o_judge, o_judge_trk);
        end else begin
          e = sb.pop_front();
          chk("judge", 32'(o_judge), 32'(e.judge));
          chk("judge_trk", 32'(o_judge_trk), 32'(e.trk));
          chk("combo", 32'(o_combo), 32'(e.combo));
          if (e.snd) begin
            chk("play_en", 32'(o_play_en), 32'd1);
            chk("cnt_limit", o_cnt_limit, e.limit);
          end
          @(negedge clk);
          chk("vld_pulse", 32'(o_judge_vld), 32'd0);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      i_tick = 1'b1;
      cyc();
      i_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic note(logic [3:0] m);
    i_note_ctr = m;
    cyc();
    i_note_ctr = '0;
  endtask

  task automatic press(logic [3:0] m);
    i_btn = i_btn | m;
    cyc();
    i_btn = i_btn & ~m;
    cyc();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_judge"}, 32'(o_judge), 32'd0);
    chk({tag, "_trk"}, 32'(o_judge_trk), 32'd0);
    chk({tag, "_vld"}, 32'(o_judge_vld), 32'd0);
    chk({tag, "_play"}, 32'(o_play_en), 32'd0);
    chk({tag, "_limit"}, o_cnt_limit, 32'd0);
    chk({tag, "_combo"}, 32'(o_combo), 32'd0);
  endtask

  initial begin
    rst = 1'b1; i_tick = 1'b0; i_btn = '0; i_note_ctr = '0;
    fork
      monitor();
    join_none
    repeat (3) cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    cyc();

    // Perfect on track 0, then sound and hold expiry boundaries.
    note(4'b0001); tick(10);
    push(GR_PERFECT_V(), 0, 1, 1'b1, pitch_of(0));
    press(4'b0001);
    tick(100);
    chk("play_after_100", 32'(o_play_en), 32'd1);
    tick(1);
    chk("play_after_101", 32'(o_play_en), 32'd0);
    chk("limit_held", o_cnt_limit, pitch_of(0));
    tick(98);
    chk("judge_hold_199", 32'(o_judge), 32'd3);
    tick(1);
    chk("judge_hold_200", 32'(o_judge), 32'd0);
    chk("trk_kept", 32'(o_judge_trk), 32'd0);

    // Good, then an unpressed note on track 2 misses on the 81st tick.
    note(4'b0001); tick(50);
    push(2'b10, 0, 2, 1'b1, pitch_of(0));
    press(4'b0001);
    note(4'b0100); tick(80);
    push(2'b01, 2, 0, 1'b1, pitch_of(0));
    tick(1);

    // Simultaneous hits on 1 and 3; then hits on 1,3 with a miss on 2.
    note(4'b1010); tick(5);
    push(2'b11, 1, 2, 1'b1, pitch_of(1));
    press(4'b1010);
    note(4'b1110); tick(80);
    push(2'b10, 1, 0, 1'b1, pitch_of(1));
    i_btn = 4'b1010; i_tick = 1'b1;
    cyc();
    i_btn = '0; i_tick = 1'b0;
    cyc();

    // Button held across the note: no hit, miss at 81 ticks.
    i_btn = 4'b0001;
    cyc();
    note(4'b0001); tick(80);
    push(2'b01, 0, 0, 1'b0, '0);
    tick(1);
    i_btn = '0;
    cyc();

    // Age 30 is Perfect, age 31 is Good.
    note(4'b0001); tick(30);
    push(2'b11, 0, 1, 1'b1, pitch_of(0));
    press(4'b0001);
    note(4'b0001); tick(31);
    push(2'b10, 0, 2, 1'b1, pitch_of(0));
    press(4'b0001);

    // Second note while pending misses the first; the new one grades normally.
    note(4'b0010); tick(10);
    push(2'b01, 1, 0, 1'b0, '0);
    note(4'b0010); tick(3);
    push(2'b11, 1, 1, 1'b1, pitch_of(1));
    press(4'b0010);

    // Reset while pending with sound on drops the note.
    note(4'b0001); tick(2);
    rst = 1'b1;
    cyc();
    chk_all_zero("midrst");
    rst = 1'b0;
    cyc();
    press(4'b0001);
    tick(3);

    // Nine consecutive hits: the 3-bit combo copy saturates at 7.
    for (int i = 1; i <= 9; i++) begin
      note(4'b0001); tick(1);
      push(2'b11, 0, i, 1'b1, pitch_of(0));
      press(4'b0001);
      chk("sat_combo", 32'(s_combo), (i > 7) ? 32'd7 : 32'(i));
    end

    repeat (4) cyc();
    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic [1:0] GR_PERFECT_V();
    return 2'b11;
  endfunction

endmodule
